rggen_wide_register_atomic: RTL and testbench

//  Register front-end for registers wider than the bus (DATA_WIDTH = N*BUS_WIDTH).
//  - Decodes the N bus words.
//  - Buffers partial writes and commits them to the bit fields as one atomic write.
//  - Snapshots the full register on a word-0 read, so later words read coherently.
//  - Inserts programmable wait states before the bus response.

---
 rtl/rggen_wide_register_atomic.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_rggen_wide_register_atomic.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rggen_wide_register_atomic.sv
// ---------------------------------------------------------------------------
// rggen_wide_register_atomic
//
// Register front-end for a register wider than the bus
// (DATA_WIDTH = WORDS * BUS_WIDTH).
//
// Its job:
//   - decode the WORDS bus words of the register
//   - collect partial writes and hand them to the bit fields as one write
//   - take a snapshot of the whole register on a word-0 read, so that the
//     later words read back consistently
//   - add WAIT_CYCLES wait states before each bus response
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_register_valid          bus request valid, held until ready
//   i_register_access         bit0: 1=write, 0=read (bit1 unused)
//   i_register_address        byte address
//   i_register_write_data     write data for one bus word
//   i_register_strobe         per-bit write mask for one bus word
//   o_register_active         address hits this register (combinational)
//   o_register_ready          one-cycle response pulse
//   o_register_status         2'b00 OKAY, 2'b10 SLVERR
//   o_register_read_data      read data, valid with ready
//   o_bit_field_read_valid    read strobe to the bit fields
//   o_bit_field_write_valid   write strobe to the bit fields
//   o_bit_field_mask          full-width write mask to the bit fields
//   o_bit_field_write_data    full-width write data to the bit fields
//   i_bit_field_read_data     current full-width bit-field value
// ---------------------------------------------------------------------------
module rggen_wide_register_atomic #(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int OFFSET_ADDRESS = 0,
  parameter int BUS_WIDTH      = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int READABLE       = 1,
  parameter int WRITABLE       = 1,
  parameter int ATOMIC_WRITE   = 1,
  parameter int ATOMIC_READ    = 1,
  parameter int WAIT_CYCLES    = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_register_valid,
  input  logic [1:0]               i_register_access,
  input  logic [ADDRESS_WIDTH-1:0] i_register_address,
  input  logic [BUS_WIDTH-1:0]     i_register_write_data,
  input  logic [BUS_WIDTH-1:0]     i_register_strobe,
  output logic                     o_register_active,
  output logic                     o_register_ready,
  output logic [1:0]               o_register_status,
  output logic [BUS_WIDTH-1:0]     o_register_read_data,
  output logic                     o_bit_field_read_valid,
  output logic                     o_bit_field_write_valid,
  output logic [DATA_WIDTH-1:0]    o_bit_field_mask,
  output logic [DATA_WIDTH-1:0]    o_bit_field_write_data,
  input  logic [DATA_WIDTH-1:0]    i_bit_field_read_data
);

  localparam int WORDS          = DATA_WIDTH / BUS_WIDTH;
  localparam int BYTES_PER_WORD = BUS_WIDTH / 8;
  localparam int IDX_W          = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CNT_W          = 4;
  localparam bit USE_AW         = (ATOMIC_WRITE != 0) && (WORDS > 1);
  localparam bit USE_AR         = (ATOMIC_READ != 0) && (WORDS > 1);

  localparam logic [ADDRESS_WIDTH:0] ADDR_LO  = (ADDRESS_WIDTH+1)'(OFFSET_ADDRESS);
  localparam logic [ADDRESS_WIDTH:0] ADDR_HI  = (ADDRESS_WIDTH+1)'(OFFSET_ADDRESS + DATA_WIDTH / 8);
  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [1:0]             STATUS_OKAY   = 2'b00;
  localparam logic [1:0]             STATUS_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ACK  = 2'b10
  } state_e;

  state_e                 state_q,        state_d;
  logic [CNT_W-1:0]       wait_cnt_q,     wait_cnt_d;
  logic                   req_write_q,    req_write_d;
  logic [IDX_W-1:0]       req_index_q,    req_index_d;
  logic [BUS_WIDTH-1:0]   req_wdata_q,    req_wdata_d;
  logic [BUS_WIDTH-1:0]   req_strobe_q,   req_strobe_d;
  logic [DATA_WIDTH-1:0]  wbuf_data_q,    wbuf_data_d;
  logic [DATA_WIDTH-1:0]  wbuf_mask_q,    wbuf_mask_d;
  logic [DATA_WIDTH-1:0]  snap_q,         snap_d;
  logic                   snap_valid_q,   snap_valid_d;
  logic                   ready_q,        ready_d;
  logic [1:0]             status_q,       status_d;
  logic [BUS_WIDTH-1:0]   read_data_q,    read_data_d;
  logic                   read_valid_q,   read_valid_d;
  logic                   write_valid_q,  write_valid_d;
  logic [DATA_WIDTH-1:0]  mask_q,         mask_d;
  logic [DATA_WIDTH-1:0]  write_data_q,   write_data_d;

  logic [ADDRESS_WIDTH-1:0] rel_addr_s;
  logic                     in_range_s;
  logic                     aligned_s;
  logic [IDX_W-1:0]         word_index_s;
  logic                     accept_s;
  logic                     go_ack_s;
  logic                     cur_write_s;
  logic [IDX_W-1:0]         cur_index_s;
  logic [BUS_WIDTH-1:0]     cur_wdata_s;
  logic [BUS_WIDTH-1:0]     cur_strobe_s;
  logic [DATA_WIDTH-1:0]    place_mask_s;
  logic [DATA_WIDTH-1:0]    place_data_s;
  logic                     unused_access_s;

  assign unused_access_s = i_register_access[1];

  // Address decode: in-range and word-aligned, plus the word index.
  assign rel_addr_s   = i_register_address - ADDRESS_WIDTH'(OFFSET_ADDRESS);
  assign in_range_s   = ({1'b0, i_register_address} >= ADDR_LO) &&
                        ({1'b0, i_register_address} <  ADDR_HI);
  assign aligned_s    = (rel_addr_s % ADDRESS_WIDTH'(BYTES_PER_WORD)) == {ADDRESS_WIDTH{1'b0}};
  assign word_index_s = IDX_W'(rel_addr_s / ADDRESS_WIDTH'(BYTES_PER_WORD));
  assign o_register_active = in_range_s && aligned_s;

  assign accept_s = (state_q == ST_IDLE) && i_register_valid && o_register_active;

  // Request being answered: live bus inputs when the response is produced on
  // the accept edge itself (no wait states), the captured copy otherwise.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_write_s  = i_register_access[0];
      cur_index_s  = word_index_s;
      cur_wdata_s  = i_register_write_data;
      cur_strobe_s = i_register_strobe;
    end else begin
      cur_write_s  = req_write_q;
      cur_index_s  = req_index_q;
      cur_wdata_s  = req_wdata_q;
      cur_strobe_s = req_strobe_q;
    end
    place_mask_s = DATA_WIDTH'(cur_strobe_s) << (int'(cur_index_s) * BUS_WIDTH);
    place_data_s = DATA_WIDTH'(cur_wdata_s)  << (int'(cur_index_s) * BUS_WIDTH);
  end

  // Next-state logic: FSM, request capture, buffers and registered response.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    req_write_d   = req_write_q;
    req_index_d   = req_index_q;
    req_wdata_d   = req_wdata_q;
    req_strobe_d  = req_strobe_q;
    wbuf_data_d   = wbuf_data_q;
    wbuf_mask_d   = wbuf_mask_q;
    snap_d        = snap_q;
    snap_valid_d  = snap_valid_q;
    ready_d       = 1'b0;
    status_d      = STATUS_OKAY;
    read_data_d   = {BUS_WIDTH{1'b0}};
    read_valid_d  = 1'b0;
    write_valid_d = 1'b0;
    mask_d        = {DATA_WIDTH{1'b0}};
    write_data_d  = {DATA_WIDTH{1'b0}};
    go_ack_s      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          req_write_d  = i_register_access[0];
          req_index_d  = word_index_s;
          req_wdata_d  = i_register_write_data;
          req_strobe_d = i_register_strobe;
          if (WAIT_CYCLES > 0) begin
            state_d    = ST_WAIT;
            wait_cnt_d = CNT_W'(WAIT_CYCLES - 1);
          end else begin
            state_d  = ST_ACK;
            go_ack_s = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == {CNT_W{1'b0}}) begin
          state_d  = ST_ACK;
          go_ack_s = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - CNT_W'(1);
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The response is computed on the edge that enters ACK so that every
    // bus and bit-field output is a flop during the ACK cycle.
    if (go_ack_s) begin
      ready_d = 1'b1;
      if (cur_write_s) begin
        if (WRITABLE == 0) begin
          status_d = STATUS_SLVERR;
        end else if (USE_AW && (cur_index_s != LAST_IDX)) begin
          // Lower words only update the buffer; new strobe bits overwrite.
          wbuf_mask_d = wbuf_mask_q | place_mask_s;
          wbuf_data_d = (wbuf_data_q & ~place_mask_s) | (place_data_s & place_mask_s);
        end else if (USE_AW) begin
          write_valid_d = 1'b1;
          mask_d        = wbuf_mask_q | place_mask_s;
          write_data_d  = (wbuf_data_q & ~place_mask_s) | (place_data_s & place_mask_s);
          wbuf_mask_d   = {DATA_WIDTH{1'b0}};
          wbuf_data_d   = {DATA_WIDTH{1'b0}};
          snap_valid_d  = 1'b0;
        end else begin
          write_valid_d = 1'b1;
          mask_d        = place_mask_s;
          write_data_d  = place_data_s;
          snap_valid_d  = 1'b0;
        end
      end else begin
        if (READABLE == 0) begin
          status_d = STATUS_SLVERR;
        end else if (USE_AR && (cur_index_s == {IDX_W{1'b0}})) begin
          read_valid_d = 1'b1;
          snap_d       = i_bit_field_read_data;
          snap_valid_d = 1'b1;
          read_data_d  = BUS_WIDTH'(i_bit_field_read_data);
        end else if (USE_AR && snap_valid_q) begin
          // Coherent upper word: no strobe, so no read side effects.
          read_data_d = BUS_WIDTH'(snap_q >> (int'(cur_index_s) * BUS_WIDTH));
        end else begin
          read_valid_d = 1'b1;
          read_data_d  = BUS_WIDTH'(i_bit_field_read_data >> (int'(cur_index_s) * BUS_WIDTH));
        end
      end
    end else begin
      ready_d = 1'b0;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= {CNT_W{1'b0}};
      req_write_q   <= 1'b0;
      req_index_q   <= {IDX_W{1'b0}};
      req_wdata_q   <= {BUS_WIDTH{1'b0}};
      req_strobe_q  <= {BUS_WIDTH{1'b0}};
      wbuf_data_q   <= {DATA_WIDTH{1'b0}};
      wbuf_mask_q   <= {DATA_WIDTH{1'b0}};
      snap_q        <= {DATA_WIDTH{1'b0}};
      snap_valid_q  <= 1'b0;
      ready_q       <= 1'b0;
      status_q      <= STATUS_OKAY;
      read_data_q   <= {BUS_WIDTH{1'b0}};
      read_valid_q  <= 1'b0;
      write_valid_q <= 1'b0;
      mask_q        <= {DATA_WIDTH{1'b0}};
      write_data_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      req_write_q   <= req_write_d;
      req_index_q   <= req_index_d;
      req_wdata_q   <= req_wdata_d;
      req_strobe_q  <= req_strobe_d;
      wbuf_data_q   <= wbuf_data_d;
      wbuf_mask_q   <= wbuf_mask_d;
      snap_q        <= snap_d;
      snap_valid_q  <= snap_valid_d;
      ready_q       <= ready_d;
      status_q      <= status_d;
      read_data_q   <= read_data_d;
      read_valid_q  <= read_valid_d;
      write_valid_q <= write_valid_d;
      mask_q        <= mask_d;
      write_data_q  <= write_data_d;
    end
  end

  assign o_register_ready        = ready_q;
  assign o_register_status       = status_q;
  assign o_register_read_data    = read_data_q;
  assign o_bit_field_read_valid  = read_valid_q;
  assign o_bit_field_write_valid = write_valid_q;
  assign o_bit_field_mask        = mask_q;
  assign o_bit_field_write_data  = write_data_q;

  rggen_wide_register_atomic_checker u_checker (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_waiting (state_q == ST_WAIT),
    .i_valid   (i_register_valid),
    .i_ready   (ready_q)
  );

endmodule

// ---------------------------------------------------------------------------
// rggen_wide_register_atomic_checker
//
// Bus protocol properties for the register front-end.
//   i_clk, i_rst_n  clock and reset
//   i_waiting       a request has been accepted and its response is pending
//   i_valid         bus request valid
//   i_ready         bus response pulse
// ---------------------------------------------------------------------------
module rggen_wide_register_atomic_checker (
  input logic i_clk,
  input logic i_rst_n,
  input logic i_waiting,
  input logic i_valid,
  input logic i_ready
);

  // The master must keep valid asserted while its response is pending.
  a_valid_held : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_waiting |-> i_valid);

  // The response is a single-cycle pulse.
  a_ready_pulse : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_ready |=> !i_ready);

endmodule

// File: tb/tb_rggen_wide_register_atomic.sv
// ---------------------------------------------------------------------------
// tb_rggen_wide_register_atomic
//
// Three instances of the 64-bit register behind a 32-bit bus:
//   dut 0: no wait states
//   dut 1: WAIT_CYCLES=3
//   dut 2: WRITABLE=0
// Directed transactions push their expected response into a queue; a monitor
// pops and compares whenever an instance raises ready.
// ---------------------------------------------------------------------------
module tb_rggen_wide_register_atomic;

  typedef struct {
    int          dut;
    logic [1:0]  status;
    logic [31:0] rdata;
    logic        rv;
    logic        wv;
    logic [63:0] mask;
    logic [63:0] wdata;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [2:0]  valid;
  logic [1:0]  access;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] strobe;
  logic [63:0] fields;

  logic [2:0]  active;
  logic [2:0]  ready;
  logic [2:0]  rv;
  logic [2:0]  wv;
  logic [1:0]  status [3];
  logic [31:0] rdata  [3];
  logic [63:0] mask   [3];
  logic [63:0] wdo    [3];

  exp_t exp_q[$];
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    rggen_wide_register_atomic #(
      .ADDRESS_WIDTH  (8),
      .OFFSET_ADDRESS (0),
      .BUS_WIDTH      (32),
      .DATA_WIDTH     (64),
      .READABLE       (1),
      .WRITABLE       ((g == 2) ? 0 : 1),
      .ATOMIC_WRITE   (1),
      .ATOMIC_READ    (1),
      .WAIT_CYCLES    ((g == 1) ? 3 : 0)
    ) dut (
      .i_clk                   (clk),
      .i_rst_n                 (rst_n),
      .i_register_valid        (valid[g]),
      .i_register_access       (access),
      .i_register_address      (addr),
      .i_register_write_data   (wdata),
      .i_register_strobe       (strobe),
      .o_register_active       (active[g]),
      .o_register_ready        (ready[g]),
      .o_register_status       (status[g]),
      .o_register_read_data    (rdata[g]),
      .o_bit_field_read_valid  (rv[g]),
      .o_bit_field_write_valid (wv[g]),
      .o_bit_field_mask        (mask[g]),
      .o_bit_field_write_data  (wdo[g]),
      .i_bit_field_read_data   (fields)
    );
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic int latency(input int d);
    return (d == 1) ? 4 : 1;
  endfunction

  // Scoreboard monitor: compares each response against the queue head.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (ready[d]) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready dut=%0d actual=ready required=no_ready", d);
        end else begin
          e = exp_q.pop_front();
          check("dut_id",      64'(d),         64'(e.dut));
          check("status",      64'(status[d]), 64'(e.status));
          check("read_data",   64'(rdata[d]),  64'(e.rdata));
          check("read_valid",  64'(rv[d]),     64'(e.rv));
          check("write_valid", 64'(wv[d]),     64'(e.wv));
          check("mask",        mask[d],        e.mask);
          check("write_data",  wdo[d],         e.wdata);
        end
      end else if (rv[d] || wv[d]) begin
        check("strobe_outside_ack", {62'd0, rv[d], wv[d]}, 64'd0);
      end
    end
  end

  // One bus transaction on dut d; expected response goes to the scoreboard.
  task automatic txn(input int d, input bit wr, input logic [7:0] a,
                     input logic [31:0] wd, input logic [31:0] st,
                     input logic [1:0] es, input logic [31:0] er,
                     input bit erv, input bit ewv,
                     input logic [63:0] em, input logic [63:0] ewd);
    exp_t e;
    int   n;
    bit   got;
    e.dut = d; e.status = es; e.rdata = er; e.rv = erv; e.wv = ewv;
    e.mask = em; e.wdata = ewd;
    exp_q.push_back(e);
    access = {1'b0, wr};
    addr   = a;
    wdata  = wd;
    strobe = st;
    valid[d] = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = ready[d];
    end
    valid[d] = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout dut=%0d actual=no_ready required=ready", d);
      exp_q.delete(exp_q.size() - 1);
    end else begin
      check("latency", 64'(n), 64'(latency(d)));
      @(negedge clk);
      check("ready_width", 64'(ready[d]), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    valid  = 3'b000;
    access = 2'b00;
    addr   = 8'h00;
    wdata  = 32'h0;
    strobe = 32'h0;
    fields = 64'h0;
    repeat (2) @(negedge clk);

    // Reset state of all instances.
    for (int d = 0; d < 3; d++) begin
      check("reset_ready",  64'(ready[d]),  64'd0);
      check("reset_status", 64'(status[d]), 64'd0);
      check("reset_rdata",  64'(rdata[d]),  64'd0);
      check("reset_strobe", {62'd0, rv[d], wv[d]}, 64'd0);
      check("reset_mask",   mask[d], 64'd0);
      check("reset_wdata",  wdo[d],  64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Decode boundaries.
    addr = 8'h00; #1 check("active_w0",         64'(active[0]), 64'd1);
    addr = 8'h04; #1 check("active_w1",         64'(active[0]), 64'd1);
    addr = 8'h08; #1 check("active_past_end",   64'(active[0]), 64'd0);
    addr = 8'h02; #1 check("active_misaligned", 64'(active[0]), 64'd0);
    @(negedge clk);

    // Atomic write: first word buffered, second commits both.
    txn(0, 1'b1, 8'h00, 32'h1111_1111, 32'hFFFF_FFFF, 2'b00, 32'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    txn(0, 1'b1, 8'h04, 32'h2222_2222, 32'hFFFF_FFFF, 2'b00, 32'h0, 1'b0, 1'b1,
        64'hFFFF_FFFF_FFFF_FFFF, 64'h2222_2222_1111_1111);

    // Partial strobes, rewrite of a buffered word, partial last word.
    txn(0, 1'b1, 8'h00, 32'hDEAD_BEEF, 32'h0000_FFFF, 2'b00, 32'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    txn(0, 1'b1, 8'h00, 32'h1234_5678, 32'h00FF_00FF, 2'b00, 32'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    txn(0, 1'b1, 8'h04, 32'hCAFE_F00D, 32'hFF00_0000, 2'b00, 32'h0, 1'b0, 1'b1,
        64'hFF00_0000_00FF_FFFF, 64'hCA00_0000_0034_BE78);

    // Atomic read: snapshot on word 0, upper word from snapshot.
    fields = 64'hAAAA_BBBB_CCCC_DDDD;
    txn(0, 1'b0, 8'h00, 32'h0, 32'h0, 2'b00, 32'hCCCC_DDDD, 1'b1, 1'b0, 64'h0, 64'h0);
    fields = 64'h1234_5678_9ABC_DEF0;
    txn(0, 1'b0, 8'h04, 32'h0, 32'h0, 2'b00, 32'hAAAA_BBBB, 1'b0, 1'b0, 64'h0, 64'h0);
    txn(0, 1'b0, 8'h00, 32'h0, 32'h0, 2'b00, 32'h9ABC_DEF0, 1'b1, 1'b0, 64'h0, 64'h0);

    // Committed write invalidates the snapshot; next upper read is live.
    txn(0, 1'b1, 8'h00, 32'h0000_0000, 32'hFFFF_FFFF, 2'b00, 32'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    txn(0, 1'b1, 8'h04, 32'h0000_0000, 32'h0000_0000, 2'b00, 32'h0, 1'b0, 1'b1,
        64'h0000_0000_FFFF_FFFF, 64'h0);
    fields = 64'h5555_6666_7777_8888;
    txn(0, 1'b0, 8'h04, 32'h0, 32'h0, 2'b00, 32'h5555_6666, 1'b1, 1'b0, 64'h0, 64'h0);

    // Wait states: latency 4 checked inside txn.
    txn(1, 1'b0, 8'h04, 32'h0, 32'h0, 2'b00, 32'h5555_6666, 1'b1, 1'b0, 64'h0, 64'h0);
    txn(1, 1'b0, 8'h00, 32'h0, 32'h0, 2'b00, 32'h7777_8888, 1'b1, 1'b0, 64'h0, 64'h0);

    // Read-only register: writes get SLVERR and no strobe.
    txn(2, 1'b1, 8'h00, 32'h1234_5678, 32'hFFFF_FFFF, 2'b10, 32'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    txn(2, 1'b0, 8'h00, 32'h0, 32'h0, 2'b00, 32'h7777_8888, 1'b1, 1'b0, 64'h0, 64'h0);
    txn(2, 1'b1, 8'h04, 32'h1234_5678, 32'hFFFF_FFFF, 2'b10, 32'h0, 1'b0, 1'b0, 64'h0, 64'h0);

    // Reset in the middle of a wait state clears the write buffer.
    txn(1, 1'b1, 8'h00, 32'h0BAD_0BAD, 32'hFFFF_FFFF, 2'b00, 32'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    access   = 2'b01;
    addr     = 8'h00;
    wdata    = 32'h0BAD_0BAD;
    strobe   = 32'hFFFF_FFFF;
    valid[1] = 1'b1;
    repeat (2) @(negedge clk);
    rst_n    = 1'b0;
    valid[1] = 1'b0;
    @(negedge clk);
    check("midreset_ready", 64'(ready[1]), 64'd0);
    check("midreset_mask",  mask[1],       64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    txn(1, 1'b1, 8'h04, 32'h600D_600D, 32'hFFFF_FFFF, 2'b00, 32'h0, 1'b0, 1'b1,
        64'hFFFF_FFFF_0000_0000, 64'h600D_600D_0000_0000);

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
